// File: rtl/cpt_activate_gen.sv
// Activate-pulse generator for the bit_cpt counter family: programmable prescaler
// plus a run-control FSM supporting continuous and fixed-length burst modes.
module cpt_activate_gen #(
    parameter int PRESCALE_W = 4,
    parameter int BURST_W    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
    input  logic [PRESCALE_W-1:0] div,
    input  logic [BURST_W-1:0]    burst_len,
    output logic                  activate,
    output logic                  busy,
    output logic                  done,
    output logic [BURST_W-1:0]    pulse_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                r_state,   w_state_nx;
    logic [PRESCALE_W-1:0] r_presc,   w_presc_nx;
    logic [PRESCALE_W-1:0] r_div_q,   w_div_nx;
    logic [BURST_W-1:0]    r_burst_q, w_burst_nx;
    logic                  r_mode_q,  w_mode_nx;
    logic [BURST_W-1:0]    r_cnt,     w_cnt_nx;
    logic                  r_act,     w_act_nx;
    logic                  r_busy,    w_busy_nx;
    logic                  r_done,    w_done_nx;
    logic [BURST_W-1:0]    w_cnt_inc;

    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        // NOTE: every signal gets a default here so no path can infer a latch.
        w_state_nx = r_state;
        w_presc_nx = r_presc;
        w_div_nx   = r_div_q;
        w_burst_nx = r_burst_q;
        w_mode_nx  = r_mode_q;
        w_cnt_nx   = r_cnt;
        w_act_nx   = 1'b0;
        w_done_nx  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_div_nx   = div;
                    w_burst_nx = burst_len;
                    w_mode_nx  = mode;
                    w_presc_nx = '0;
                    w_cnt_nx   = '0;
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                // stop outranks both the empty-burst exit and a pulse due this edge
                if (stop) begin
                    w_state_nx = S_IDLE;
                end else if (r_mode_q && (r_burst_q == '0)) begin
                    w_state_nx = S_DONE;
                end else if (r_presc == r_div_q) begin
                    w_presc_nx = '0;
                    w_act_nx   = 1'b1;
                    w_cnt_nx   = w_cnt_inc;
                    if (r_mode_q && (w_cnt_inc == r_burst_q)) begin
                        w_state_nx = S_DONE;
                    end
                end else begin
                    w_presc_nx = r_presc + 1'b1;
                end
            end
            S_DONE: begin
                w_done_nx  = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // busy covers the last pulse's cycle and drops together with done
        w_busy_nx = (w_state_nx != S_IDLE);
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_div_q   <= '0;
            r_burst_q <= '0;
            r_mode_q  <= 1'b0;
            r_cnt     <= '0;
            r_act     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_presc   <= w_presc_nx;
            r_div_q   <= w_div_nx;
            r_burst_q <= w_burst_nx;
            r_mode_q  <= w_mode_nx;
            r_cnt     <= w_cnt_nx;
            r_act     <= w_act_nx;
            r_busy    <= w_busy_nx;
            r_done    <= w_done_nx;
        end
    end

    assign activate  = r_act;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pulse_cnt = r_cnt;

endmodule

// File: tb/tb_cpt_activate_gen.sv
// Scoreboard bench for cpt_activate_gen: each driven cycle queues the expected
// post-edge outputs, and a monitor pops and compares them just after the edge.
module tb_cpt_activate_gen;

    localparam int PW = 4;
    localparam int BW = 3;

    logic          clk;
    logic          reset;
    logic          start;
    logic          stop;
    logic          mode;
    logic [PW-1:0] div;
    logic [BW-1:0] burst_len;
    logic          activate;
    logic          busy;
    logic          done;
    logic [BW-1:0] pulse_cnt;

    typedef struct {
        string         tag;
        logic          act;
        logic          busy;
        logic          done;
        logic [BW-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    cpt_activate_gen #(
        .PRESCALE_W(PW),
        .BURST_W   (BW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .div      (div),
        .burst_len(burst_len),
        .activate (activate),
        .busy     (busy),
        .done     (done),
        .pulse_cnt(pulse_cnt)
    );

    // rising edges at 10, 20, ... so the 5-unit reset release never meets an edge
    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, "_act"},  int'(activate),  int'(e.act));
            check({e.tag, "_busy"}, int'(busy),      int'(e.busy));
            check({e.tag, "_done"}, int'(done),      int'(e.done));
            check({e.tag, "_cnt"},  int'(pulse_cnt), int'(e.cnt));
        end
    end

    function automatic exp_t idle_exp(input string tag, input int cnt);
        exp_t e;
        e.tag  = tag;
        e.act  = 1'b0;
        e.busy = 1'b0;
        e.done = 1'b0;
        e.cnt  = BW'(cnt);
        return e;
    endfunction

    // Outputs in the cycle after edge Ek, where E0 is the start edge.
    function automatic exp_t model(input string tag, input int d, input int len,
                                   input bit burst, input int k);
        exp_t e;
        int   p;
        int   last;
        int   n;
        p     = d + 1;
        n     = k / p;
        e.tag = $sformatf("%s_k%0d", tag, k);
        if (!burst) begin
            e.act  = (k > 0) && (k % p == 0);
            e.busy = 1'b1;
            e.done = 1'b0;
            e.cnt  = BW'(n % (1 << BW));
        end else begin
            last   = (len == 0) ? 1 : len * p;
            e.act  = (k > 0) && (k % p == 0) && (n <= len);
            e.busy = (k <= last);
            e.done = (k == last + 1);
            e.cnt  = BW'((n < len) ? n : len);
        end
        return e;
    endfunction

    task automatic drive(input logic st, input logic sp, input exp_t e);
        @(negedge clk);
        start = st;
        stop  = sp;
        sb_q.push_back(e);
    endtask

    // Launch a run at k=0 and drive ncyc cycles; stop is raised for edge stop_at (-1 = never).
    // A stray start and a new div mid-run must both be ignored.
    task automatic run(input string tag, input int d, input int len, input bit burst,
                       input int ncyc, input int stop_at);
        exp_t e;
        bit   stopped;
        int   held;
        stopped = 1'b0;
        held    = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (k == 0) begin
                mode      = burst;
                div       = PW'(d);
                burst_len = BW'(len);
            end
            if (k == 2) begin
                div  = ~PW'(d);
                mode = ~burst;
            end
            if (k == stop_at) stopped = 1'b1;
            if (stopped) begin
                e = idle_exp($sformatf("%s_k%0d", tag, k), held);
            end else begin
                e    = model(tag, d, len, burst, k);
                held = int'(e.cnt);
            end
            drive((k == 0) || (k == 2 && k != stop_at), (k == stop_at), e);
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        mode      = 1'b0;
        div       = '0;
        burst_len = '0;
        #1;
        check("reset_act",  int'(activate),  0);
        check("reset_busy", int'(busy),      0);
        check("reset_done", int'(done),      0);
        check("reset_cnt",  int'(pulse_cnt), 0);
        #4;
        reset = 1'b0;

        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, idle_exp($sformatf("idle%0d", i), 0));

        run("cont_d3", 3, 0, 1'b0, 19, 18);
        drive(1'b0, 1'b0, idle_exp("cont_d3_after", 4));

        run("burst_d1_l5", 1, 5, 1'b1, 13, -1);

        run("burst_d0_l3", 0, 3, 1'b1, 7, -1);

        run("burst_l0", 2, 0, 1'b1, 5, -1);

        run("stop_coll", 2, 0, 1'b0, 8, 6);

        // asynchronous reset between edges in the middle of a burst
        run("rst_burst", 1, 5, 1'b1, 5, -1);
        @(negedge clk);
        #2;
        check("rst_pre_cnt", int'(pulse_cnt), 2);
        reset = 1'b1;
        #1;
        check("rst_async_act",  int'(activate),  0);
        check("rst_async_busy", int'(busy),      0);
        check("rst_async_done", int'(done),      0);
        check("rst_async_cnt",  int'(pulse_cnt), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mode  = 1'b0;
        div   = '0;
        drive(1'b1, 1'b1, idle_exp("start_stop", 0));
        drive(1'b0, 1'b0, idle_exp("start_stop_idle", 0));
        run("fresh_d2", 2, 0, 1'b0, 8, 7);

        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("sb_drain", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpt_activate_gen.md
Name: cpt_activate_gen

Overview:
- Upstream stage of the bit_cpt counter family. Generates the single-cycle `activate` enable that advances a downstream counter such as bit_cpt3.
- Provides a programmable prescaler plus a run-control FSM with two modes: continuous and fixed-length burst.
- `activate` connects directly to the counter's activate input. The counter shares `clk` and `reset` with this block.

Parameters:
- PRESCALE_W, 4, width of the prescaler and of `div`. Pulse period is div+1 clocks.
- BURST_W, 3, width of `burst_len` and `pulse_cnt`. Matches the 3-bit counter.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level sampled on each clock edge. Launches a run from IDLE.
- stop  in  1  level sampled on each clock edge. Aborts a run.
- mode  in  1  0 = continuous, 1 = burst.
- div  in  PRESCALE_W  period minus 1. Latched at start.
- burst_len  in  BURST_W  number of pulses in burst mode. Latched at start.
- activate  out  1  registered, one-clock-wide enable pulse.
- busy  out  1  high while in RUN.
- done  out  1  one-clock pulse at burst completion.
- pulse_cnt  out  BURST_W  number of activate pulses issued in the current run.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; prescaler=0; activate=0; busy=0; done=0; pulse_cnt=0; latched div_q=0, burst_q=0, mode_q=0.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE, start=1 and stop=0 at an edge:
  - Latch div, burst_len and mode.
  - Clear the prescaler and pulse_cnt.
  - Go to RUN. busy=1 from this edge.
- IDLE, start=1 and stop=1 at the same edge: stop wins; remain in IDLE.
- RUN, pulse timing:
  - The prescaler increments every edge.
  - When prescaler==div_q at an edge: the prescaler wraps to 0, activate=1 for exactly the following cycle, and pulse_cnt increments.
  - Call the start edge E0. Pulses follow edges E(div_q+1), E(2*(div_q+1)), and so on.
  - div_q=0 gives activate=1 every cycle after E0.
- RUN, continuous mode: pulse_cnt wraps modulo 2^BURST_W. The run continues until stop.
- RUN, burst mode: at the edge that issues pulse number burst_q, the activate pulse is still emitted and the FSM goes to DONE.
- RUN, burst_q=0: no activate is issued; go to DONE at the first edge after E0.
- DONE: done=1 and busy=0 for one cycle; pulse_cnt holds its final value; next edge goes to IDLE.
- After DONE, pulse_cnt holds until the next start.
- stop=1 in RUN:
  - Next edge goes to IDLE with activate=0 and busy=0; no done pulse; pulse_cnt holds.
  - stop has priority over a pulse due at the same edge; that pulse is suppressed and not counted.
- start while in RUN or DONE is ignored. Changes to div, burst_len or mode during a run are ignored.
- Reset asserted mid-run: all outputs drop to their reset values immediately, without waiting for a clock edge. After reset release, the block sits in IDLE and waits for a new start.
- activate is never high two consecutive cycles unless div_q=0.

Test Plan:
- Reset then idle: reset=1 for 5 time units, then 0, with start=0 -> activate, busy, done and pulse_cnt stay 0 indefinitely.
- Continuous, div=3, mode=0, start pulse -> activate high 1 cycle after each of edges E4, E8, E12, E16; pulse_cnt reads 1,2,3,4. Driving bit_cpt3 with it gives cpt reaching 4 at E16+1.
- Burst, div=1, burst_len=5, mode=1 -> exactly 5 activate pulses spaced 2 clocks apart; done=1 for 1 cycle right after the 5th pulse; pulse_cnt=5 holds; busy falls with done.
- Edge values:
  - div=0, burst_len=3 -> activate high 3 consecutive cycles, then done.
  - burst_len=0 -> no activate; done pulses 1 cycle after start.
- Stop collision: div=2, continuous; assert stop at the edge where the 2nd pulse is due -> no 2nd pulse; IDLE; pulse_cnt=1; done stays 0.
- Async reset mid-burst: reset asserted between edges during RUN -> outputs clear without a clock edge. After release, start=1 with stop=1 keeps IDLE; a later start alone launches a fresh run from pulse_cnt=0.
